// File: rtl/alu_result_ascii_tx_if.sv
// rtl/alu_result_ascii_tx_if.sv - byte handshake between the line formatter and the UART transmitter
interface alu_result_ascii_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  // Formatter side: offers bytes, watches the transmitter busy flag
  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy
  );

  // UART side: accepts bytes, reports busy while a frame is on the wire
  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy
  );
endinterface

// File: rtl/alu_result_ascii_tx.sv
// rtl/alu_result_ascii_tx.sv - streams a latched ALU result to the UART as "HHHH FFFFF\r\n"
module alu_result_ascii_tx #(
  parameter bit UPPERCASE   = 1'b1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk_100M,
  input  logic                  reset_n,
  input  logic                  send_result,
  input  logic [15:0]           alu_out,
  input  logic [4:0]            alu_flags,
  output logic                  busy,
  output logic                  dropped,
  alu_result_ascii_tx_if.master uart
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Nibble values 10..15 land on 'A'..'F' (0x37 + n) or 'a'..'f' (0x57 + n)
  localparam logic [7:0] HEX_ALPHA_BASE = UPPERCASE ? 8'h37 : 8'h57;
  // Counter value on the last cycle spent waiting for the UART to go busy
  localparam logic [7:0] ACK_LAST       = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] LAST_IDX       = 4'd11;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] res_q, res_d;
  logic [4:0]  flg_q, flg_d;
  logic [7:0]  ack_cnt_q, ack_cnt_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        dropped_q, dropped_d;
  logic [7:0]  cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (HEX_ALPHA_BASE + {4'h0, n});
  endfunction

  // Character at the current line position, taken from the captured result and flags
  always_comb begin
    cur_byte = 8'h0A;
    case (idx_q)
      4'd0:    cur_byte = hex_char(res_q[15:12]);
      4'd1:    cur_byte = hex_char(res_q[11:8]);
      4'd2:    cur_byte = hex_char(res_q[7:4]);
      4'd3:    cur_byte = hex_char(res_q[3:0]);
      4'd4:    cur_byte = 8'h20;
      4'd5:    cur_byte = {7'h18, flg_q[4]};
      4'd6:    cur_byte = {7'h18, flg_q[3]};
      4'd7:    cur_byte = {7'h18, flg_q[2]};
      4'd8:    cur_byte = {7'h18, flg_q[1]};
      4'd9:    cur_byte = {7'h18, flg_q[0]};
      4'd10:   cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Next-state and next-output logic for the per-byte handshake with the UART
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    res_d      = res_q;
    flg_d      = flg_q;
    ack_cnt_d  = ack_cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    // Any strobe outside IDLE is refused, including the cycle WAIT_DONE hands back to IDLE
    dropped_d  = send_result && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (send_result) begin
          res_d   = alu_out;
          flg_d   = alu_flags;
          idx_d   = 4'd0;
          state_d = START;
        end
      end
      START: begin
        if (!uart.tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          ack_cnt_d  = 8'd0;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A UART that never raises busy must not stall the line forever
        if (uart.tx_busy || (ack_cnt_q == ACK_LAST)) begin
          state_d = WAIT_DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!uart.tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captures and registered UART outputs; reset abandons any partial line
  always_ff @(posedge clk_100M) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      res_q      <= 16'h0000;
      flg_q      <= 5'b00000;
      ack_cnt_q  <= 8'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
      ack_cnt_q  <= ack_cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      dropped_q  <= dropped_d;
    end
  end

  assign uart.tx_start = tx_start_q;
  assign uart.tx_data  = tx_data_q;
  assign busy          = (state_q != IDLE);
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_alu_result_ascii_tx.sv
// tb/tb_alu_result_ascii_tx.sv - self-checking bench for alu_result_ascii_tx (upper- and lowercase builds)
module tb_alu_result_ascii_tx;
  localparam int ACK   = 15;
  localparam int FRAME = 50;

  logic        clk_100M = 1'b0;
  logic        reset_n;
  logic        send_result;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;
  logic        busy_w[2];
  logic        dropped_w[2];
  logic        st[2];
  logic [7:0]  td[2];
  logic        txb[2];
  bit          force_busy = 1'b0;
  int          mode = 0;   // 0: UART goes busy 1 cycle after tx_start; 1: UART never goes busy

  bit          ub[2]   = '{1'b0, 1'b0};
  int          ucnt[2] = '{0, 0};

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  int          phase[2];      // 0 idle, 1 line in progress, 2 after byte 11 until busy drops
  int          pcount[2];
  int          exp_drop[2];   // 2 = unknown
  int          acc_cyc[2];
  int          first_lat[2];
  int          tail_cyc[2];
  int          fall_at[2];
  int          drops[2];
  bit          prev_st[2];
  bit          prev_txb[2];
  bit          rose[2];
  bit          fresh[2] = '{1'b1, 1'b1};
  logic [7:0]  exp_line[2][12];
  logic [7:0]  got[2][12];
  int          pt[2][12];

  alu_result_ascii_tx_if bus0 ();
  alu_result_ascii_tx_if bus1 ();

  alu_result_ascii_tx #(.UPPERCASE(1'b1), .ACK_TIMEOUT(ACK)) u_dut_uc (
    .clk_100M   (clk_100M),
    .reset_n    (reset_n),
    .send_result(send_result),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .busy       (busy_w[0]),
    .dropped    (dropped_w[0]),
    .uart       (bus0)
  );

  alu_result_ascii_tx #(.UPPERCASE(1'b0), .ACK_TIMEOUT(ACK)) u_dut_lc (
    .clk_100M   (clk_100M),
    .reset_n    (reset_n),
    .send_result(send_result),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .busy       (busy_w[1]),
    .dropped    (dropped_w[1]),
    .uart       (bus1)
  );

  assign st[0] = bus0.tx_start;
  assign st[1] = bus1.tx_start;
  assign td[0] = bus0.tx_data;
  assign td[1] = bus1.tx_data;
  assign bus0.tx_busy = ub[0] | force_busy;
  assign bus1.tx_busy = ub[1] | force_busy;
  assign txb[0] = bus0.tx_busy;
  assign txb[1] = bus1.tx_busy;

  always #5 clk_100M = ~clk_100M;

  // UART models: frame of FRAME cycles, independent of the formatter's reset
  always @(posedge clk_100M) begin
    for (int k = 0; k < 2; k++) begin
      if (ub[k]) begin
        if (ucnt[k] == 1) ub[k] <= 1'b0;
        ucnt[k] <= ucnt[k] - 1;
      end else if (st[k] && mode == 0) begin
        ub[k]   <= 1'b1;
        ucnt[k] <= FRAME;
      end
    end
  end

  task automatic chk(input bit ok, input string name, input int k, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, k, act, req);
    end
  endtask

  // Expected line written as formatted text: "%04h %05b" then CR LF
  task automatic build_line(input int k, input logic [15:0] v, input logic [4:0] f);
    string s;
    logic [7:0] c;
    s = $sformatf("%04h %05b", v, f);
    for (int i = 0; i < 10; i++) begin
      c = s[i];
      if (k == 0 && c >= "a" && c <= "f") c = c - 8'h20;
      exp_line[k][i] = c;
    end
    exp_line[k][10] = 8'h0D;
    exp_line[k][11] = 8'h0A;
  endtask

  // Model-based compare, sampled on the falling edge
  always @(negedge clk_100M) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (exp_drop[k] != 2)
        chk(int'(dropped_w[k]) == exp_drop[k], "dropped", k, int'(dropped_w[k]), exp_drop[k]);
      if (dropped_w[k]) drops[k]++;

      if (phase[k] == 0) begin
        chk(busy_w[k] == 1'b0, "busy_idle", k, int'(busy_w[k]), 0);
      end else if (phase[k] == 1) begin
        chk(busy_w[k] == 1'b1, "busy_line", k, int'(busy_w[k]), 1);
      end else begin
        tail_cyc[k]++;
        if (txb[k]) rose[k] = 1'b1;
        else if (rose[k] && fall_at[k] < 0) fall_at[k] = cyc;
        if (!busy_w[k]) begin
          if (rose[k]) chk(fall_at[k] >= 0 && cyc == fall_at[k] + 1, "busy_fall", k, cyc - fall_at[k], 1);
          else         chk(tail_cyc[k] <= ACK + 3, "busy_fall_timeout", k, tail_cyc[k], ACK + 3);
          phase[k] = 0;
        end else if (tail_cyc[k] > 500) begin
          chk(1'b0, "busy_stuck", k, tail_cyc[k], 500);
          phase[k] = 0;
        end
      end

      if (st[k]) begin
        chk(phase[k] == 1, "start_unexpected", k, phase[k], 1);
        chk(!prev_st[k], "start_back_to_back", k, 1, 0);
        chk(!prev_txb[k], "start_while_tx_busy", k, 1, 0);
        if (phase[k] == 1) begin
          chk(td[k] == exp_line[k][pcount[k]], "tx_data", k, int'(td[k]), int'(exp_line[k][pcount[k]]));
          got[k][pcount[k]] = td[k];
          pt[k][pcount[k]]  = cyc;
          if (pcount[k] == 0) first_lat[k] = cyc - acc_cyc[k];
          pcount[k]++;
          if (pcount[k] == 12) begin
            phase[k]    = 2;
            tail_cyc[k] = 0;
            rose[k]     = 1'b0;
            fall_at[k]  = -1;
          end
        end
      end
      if (phase[k] == 0 && fresh[k]) chk(td[k] == 8'h00, "tx_data_after_reset", k, int'(td[k]), 0);

      prev_st[k]  = st[k];
      prev_txb[k] = txb[k];
      exp_drop[k] = 0;
      if (!reset_n) begin
        phase[k] = 0;
        fresh[k] = 1'b1;
      end else if (send_result) begin
        if (phase[k] == 0) begin
          phase[k]   = 1;
          pcount[k]  = 0;
          fresh[k]   = 1'b0;
          acc_cyc[k] = cyc;
          for (int i = 0; i < 12; i++) got[k][i] = 8'h00;
          build_line(k, alu_out, alu_flags);
        end else if (phase[k] == 1) begin
          exp_drop[k] = 1;
        end else begin
          exp_drop[k] = 2;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input logic [4:0] f);
    alu_out     = v;
    alu_flags   = f;
    send_result = 1'b1;
    tick(1);
    send_result = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1] || txb[0] || txb[1]) && n < 3000) begin
      tick(1);
      n++;
    end
    chk(n < 3000, name, 0, n, 3000);
    tick(2);
  endtask

  task automatic wait_pulses(input int target, input string name);
    int n;
    n = 0;
    while (pcount[0] < target && n < 3000) begin
      tick(1);
      n++;
    end
    chk(n < 3000, name, 0, n, 3000);
  endtask

  task automatic chk_line(input int k, input logic [95:0] lit, input string name);
    for (int i = 0; i < 12; i++)
      chk(got[k][i] == lit[95-8*i -: 8], name, k, int'(got[k][i]), int'(lit[95-8*i -: 8]));
  endtask

  initial begin
    int d0, d1, gap;
    reset_n     = 1'b0;
    send_result = 1'b0;
    alu_out     = 16'h0000;
    alu_flags   = 5'b00000;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    chk(busy_w[0] == 1'b0 && dropped_w[0] == 1'b0 && st[0] == 1'b0 && td[0] == 8'h00,
        "idle_after_reset", 0, int'(td[0]), 0);

    // Basic line, both letter cases
    send(16'h1A2F, 5'b10010);
    wait_done("line_1a2f_timeout");
    chk(pcount[0] == 12, "line_1a2f_count", 0, pcount[0], 12);
    chk(first_lat[0] == 2, "first_pulse_latency", 0, first_lat[0], 2);
    chk_line(0, 96'h31413246_20313030_31300D0A, "line_1a2f_uc");
    chk_line(1, 96'h31613266_20313030_31300D0A, "line_1a2f_lc");

    send(16'hBEEF, 5'b00000);
    wait_done("line_beef_timeout");
    chk_line(1, 96'h62656566_20303030_30300D0A, "line_beef_lc");
    chk_line(0, 96'h42454546_20303030_30300D0A, "line_beef_uc");

    // Strobe during byte 3 is dropped; the line in flight is unchanged
    d0 = drops[0];
    d1 = drops[1];
    send(16'h1A2F, 5'b10010);
    wait_pulses(4, "drop_wait_byte3");
    send(16'h0001, 5'b10010);
    wait_done("drop_line_timeout");
    chk(drops[0] - d0 == 1, "dropped_count", 0, drops[0] - d0, 1);
    chk(drops[1] - d1 == 1, "dropped_count", 1, drops[1] - d1, 1);
    chk_line(0, 96'h31413246_20313030_31300D0A, "drop_line_unchanged");
    send(16'h0001, 5'b10010);
    wait_done("line_0001_timeout");
    chk_line(0, 96'h30303031_20313030_31300D0A, "line_0001");

    // UART busy at the strobe holds off byte 0
    force_busy = 1'b1;
    send(16'h1A2F, 5'b10010);
    tick(100);
    chk(pcount[0] == 0, "held_off_while_tx_busy", 0, pcount[0], 0);
    chk(busy_w[0] == 1'b1, "busy_while_held", 0, int'(busy_w[0]), 1);
    force_busy = 1'b0;
    wait_pulses(1, "held_first_pulse");
    chk(got[0][0] == 8'h31, "held_first_byte", 0, int'(got[0][0]), 8'h31);
    wait_done("held_line_timeout");

    // UART that never acknowledges: each byte advances on the timeout
    mode = 1;
    send(16'h1A2F, 5'b10010);
    wait_done("timeout_line_timeout");
    chk(pcount[0] == 12, "timeout_count", 0, pcount[0], 12);
    chk_line(0, 96'h31413246_20313030_31300D0A, "timeout_line");
    for (int i = 1; i < 12; i++) begin
      gap = pt[0][i] - pt[0][i-1];
      chk(gap >= ACK + 1 && gap <= ACK + 3, "ack_timeout_gap", 0, gap, ACK + 2);
    end
    mode = 0;

    // Reset during byte 5 abandons the line; next strobe restarts at byte 0
    send(16'h1A2F, 5'b10010);
    wait_pulses(6, "reset_wait_byte5");
    reset_n = 1'b0;
    tick(1);
    chk(st[0] == 1'b0 && busy_w[0] == 1'b0 && td[0] == 8'h00, "reset_midline", 0, int'(td[0]), 0);
    chk(st[1] == 1'b0 && busy_w[1] == 1'b0 && td[1] == 8'h00, "reset_midline", 1, int'(td[1]), 0);
    reset_n = 1'b1;
    wait_done("reset_uart_drain");
    send(16'hBEEF, 5'b00000);
    wait_done("restart_line_timeout");
    chk(pcount[0] == 12, "restart_count", 0, pcount[0], 12);
    chk_line(0, 96'h42454546_20303030_30300D0A, "restart_line");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_ascii_tx.md
# alu_result_ascii_tx

Formats a latched ALU result as a 12-byte ASCII line and streams it byte by byte into the UART transmitter. The line is 4 hex digits of the 16-bit result, a space, 5 binary flag characters, then CR LF. The block sits downstream of the ALU and the `send_result` strobe, and upstream of `uart_basic` (`tx_start`/`tx_data`/`tx_busy`). It gives a human-readable terminal echo alongside the raw-byte result path.

## Interface
- `UPPERCASE`, 1, 1 = hex letters `A`–`F` (0x41–0x46); 0 = `a`–`f` (0x61–0x66)
- `ACK_TIMEOUT`, 15, cycles to wait in WAIT_ACK for `tx_busy` to rise before treating the byte as accepted (range 1–255)
- `clk_100M`  in  1  system clock, 100 MHz; all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `send_result`  in  1  one-cycle strobe: capture `alu_out`/`alu_flags` and send a line
- `alu_out`  in  16  ALU result, sampled only on an accepted `send_result`
- `alu_flags`  in  5  ALU flags, sampled with `alu_out`
- `tx_busy`  in  1  UART transmitter busy
- `tx_start`  out  1  one-cycle pulse: UART loads `tx_data`
- `tx_data`  out  8  byte to transmit; registered
- `busy`  out  1  high while a line is in progress (any state but IDLE)
- `dropped`  out  1  one-cycle pulse: `send_result` arrived while `busy` was high

## Operation
- Capture registers: `res_q[15:0]` and `flg_q[4:0]`, loaded only when `send_result` is high in IDLE.
- Byte index `idx` runs 0..11. Byte order:
  - 0–3: hex nibbles `res_q[15:12]`, `[11:8]`, `[7:4]`, `[3:0]`.
  - 4: 0x20.
  - 5–9: `flg_q[4]`..`flg_q[0]`, each as 0x30/0x31.
  - 10: 0x0D.
  - 11: 0x0A.
- Hex encoding: nibble 0–9 → 0x30+n; nibble 10–15 → 0x41+(n-10) (UPPERCASE=1) or 0x61+(n-10) (UPPERCASE=0).
- FSM states: IDLE, START, WAIT_ACK, WAIT_DONE.
  - IDLE: on `send_result`, capture inputs, `idx`←0, go to START.
  - START: if `tx_busy`=0, drive `tx_data`←byte(`idx`) and `tx_start`←1 for one cycle, clear the timeout counter, go to WAIT_ACK. Otherwise stay in START.
  - WAIT_ACK: on `tx_busy`=1, go to WAIT_DONE. If the counter reaches `ACK_TIMEOUT` with no rise, go to WAIT_DONE anyway.
  - WAIT_DONE: on `tx_busy`=0, if `idx`=11 go to IDLE, else `idx`←`idx`+1 and go to START.
- `tx_data` holds its value from the START pulse until the next START pulse. It is 0x00 only after reset.
- `send_result` while not in IDLE:
  - ignored; captures unchanged; `dropped` pulses the next cycle.
  - This includes the cycle in which WAIT_DONE exits to IDLE.
- `alu_out`/`alu_flags` changing mid-line has no effect on the line.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0x00, `busy`=0, `dropped`=0, state=IDLE, `idx`=0, captures=0.
- Reset asserted mid-line: next edge returns to IDLE with `tx_start`=0. The partial line is abandoned, with no CR LF. The byte already handed to the UART completes inside the UART.
- `send_result` high at edge N → `busy`=1 after N. If `tx_busy`=0, the `tx_start` pulse for byte 0 is high in cycle N+1.
- `tx_start` is never high in two consecutive cycles. It is never asserted while `tx_busy`=1 is sampled in START.
- Per-byte overhead beyond UART frame time: ≤3 cycles with a responsive UART (busy rises 1 cycle after `tx_start`).
- `busy` falls in the cycle after `tx_busy` falls following byte 11.
- `dropped` is registered: high exactly 1 cycle, one cycle after the offending strobe.

## Test plan
- Reset, then idle 20 cycles → `tx_start`=0, `tx_data`=0x00, `busy`=0, `dropped`=0 throughout.
- UART model (busy 1 cycle after `tx_start`, frame 50 cycles); `alu_out`=0x1A2F, `alu_flags`=5'b10010, `send_result` pulse → exactly 12 `tx_start` pulses carrying 31 41 32 46 20 31 30 30 31 30 0D 0A. First pulse at N+1. `busy` drops after the last frame.
- UPPERCASE=0, `alu_out`=0xBEEF, flags=0 → bytes 62 65 65 66 20 30 30 30 30 30 0D 0A.
- `send_result` with `alu_out`=0x0001 during byte 3 of a 0x1A2F line → `dropped` one pulse; line bytes unchanged. New strobe after `busy`=0 → line starts 30 30 30 31.
- `tx_busy` forced high for 100 cycles at the strobe → no `tx_start` until `tx_busy` falls, then byte 0x31 pulses. Separately, UART that never raises busy → each byte advances after `ACK_TIMEOUT` cycles; 12 pulses total.
- Assert `reset_n`=0 for 1 cycle during byte 5 → `tx_start`=0, `busy`=0, `tx_data`=0x00 next cycle. Following strobe restarts at byte 0.
